// File: rtl/cnt_10_chain_ctrl.sv
// Start/stop/clear/load sequencer for a cascade of BCD decade counters driven by a prescaled tick.
// Optional compare/stop-on-match feature enabled by defining CNT_CHAIN_CMP_EN.
module cnt_10_chain_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10,
   parameter int PS_W     = 8
) (
   input  logic                  CLK,
   input  logic                  RES,
   input  logic                  START,
   input  logic                  STOP,
   input  logic                  CLEAR,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
`ifdef CNT_CHAIN_CMP_EN
   input  logic [4*DIGITS-1:0]   CMP_VAL,
   output logic                  MATCH,
`endif
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  CARRY,
   output logic                  RUNNING,
   output logic [1:0]            STATE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
   localparam logic [PS_W-1:0] PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

   state_t                state_r;
   logic [PS_W-1:0]       ps_r;
   logic [4*DIGITS-1:0]   bcd_r;
   logic                  carry_r;
   logic                  running_r;
   logic [4*DIGITS-1:0]   bcd_inc_s;
   logic                  chain_s;
   logic                  all_nine_s;
   logic                  tick_s;
   logic                  hit_s;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [4*DIGITS-1:0] clamp_word(input logic [4*DIGITS-1:0] w);
      logic [4*DIGITS-1:0] r;
      r = w;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = clamp_digit(w[4*i +: 4]);
      end
      return r;
   endfunction

`ifdef CNT_CHAIN_CMP_EN
   logic match_r;

   // A compare word holding any non-decimal nibble can never be reached by the counter.
   function automatic logic cmp_valid(input logic [4*DIGITS-1:0] w);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction
`endif

   // Single-edge increment of the whole cascade: each digit steps when all lower digits are 9.
   always_comb begin
      bcd_inc_s = bcd_r;
      chain_s   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (chain_s) begin
            bcd_inc_s[4*i +: 4] = (bcd_r[4*i +: 4] == 4'd9) ? 4'd0 : bcd_r[4*i +: 4] + 4'd1;
         end else begin
            bcd_inc_s[4*i +: 4] = bcd_r[4*i +: 4];
         end
         chain_s = chain_s && (bcd_r[4*i +: 4] == 4'd9);
      end
      all_nine_s = chain_s;
   end

   // Prescaler terminal count qualifies the tick; compare hit is judged on the post-increment value.
   always_comb begin
      tick_s = (state_r == ST_RUN) && (ps_r == PS_LAST);
`ifdef CNT_CHAIN_CMP_EN
      hit_s  = tick_s && cmp_valid(CMP_VAL) && (bcd_inc_s == CMP_VAL);
`else
      hit_s  = 1'b0;
`endif
   end

   // Command FSM, prescaler and counter register, all outputs registered.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state_r   <= ST_IDLE;
         ps_r      <= PS_ZERO;
         bcd_r     <= {(4*DIGITS){1'b0}};
         carry_r   <= 1'b0;
         running_r <= 1'b0;
`ifdef CNT_CHAIN_CMP_EN
         match_r   <= 1'b0;
`endif
      end else begin
         carry_r <= 1'b0;
`ifdef CNT_CHAIN_CMP_EN
         match_r <= 1'b0;
`endif
         if (CLEAR) begin
            bcd_r     <= {(4*DIGITS){1'b0}};
            ps_r      <= PS_ZERO;
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
         end else if (LOAD) begin
            bcd_r     <= clamp_word(LOAD_VAL);
            ps_r      <= PS_ZERO;
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  ps_r <= PS_ZERO;
                  if (!STOP && START) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_IDLE;
                     running_r <= 1'b0;
                  end
               end
               ST_RUN: begin
                  // STOP on a tick edge drops the increment and leaves the prescaler at terminal count.
                  if (STOP) begin
                     state_r   <= ST_PAUSE;
                     running_r <= 1'b0;
                  end else if (tick_s) begin
                     ps_r    <= PS_ZERO;
                     bcd_r   <= bcd_inc_s;
                     carry_r <= all_nine_s;
                     if (hit_s) begin
                        state_r   <= ST_DONE;
                        running_r <= 1'b0;
`ifdef CNT_CHAIN_CMP_EN
                        match_r   <= 1'b1;
`endif
                     end else begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                     end
                  end else begin
                     ps_r      <= ps_r + PS_ONE;
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end
               end
               ST_PAUSE, ST_DONE: begin
                  if (!STOP && START) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= state_r;
                     running_r <= 1'b0;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  ps_r      <= PS_ZERO;
                  running_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign BCD     = bcd_r;
   assign CARRY   = carry_r;
   assign RUNNING = running_r;
   assign STATE   = state_r;
`ifdef CNT_CHAIN_CMP_EN
   assign MATCH   = match_r;
`endif

endmodule

// File: tb/tb_cnt_10_chain_ctrl.sv
// Directed table-driven bench for cnt_10_chain_ctrl (DIGITS=4, PRESCALE=3), plus hand sequences.
module tb_cnt_10_chain_ctrl;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 3;
   localparam int PS_W     = 8;

   logic        CLK = 1'b0;
   logic        RES;
   logic        START, STOP, CLEAR, LOAD;
   logic [15:0] LOAD_VAL;
   logic [15:0] BCD;
   logic        CARRY, RUNNING;
   logic [1:0]  STATE;
`ifdef CNT_CHAIN_CMP_EN
   logic [15:0] CMP_VAL;
   logic        MATCH;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   cnt_10_chain_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PS_W(PS_W)) dut (
      .CLK(CLK), .RES(RES), .START(START), .STOP(STOP), .CLEAR(CLEAR), .LOAD(LOAD),
      .LOAD_VAL(LOAD_VAL),
`ifdef CNT_CHAIN_CMP_EN
      .CMP_VAL(CMP_VAL), .MATCH(MATCH),
`endif
      .BCD(BCD), .CARRY(CARRY), .RUNNING(RUNNING), .STATE(STATE)
   );

   typedef struct {
      logic        st, sp, cl, ld;
      logic [15:0] lv;
      logic [15:0] bcd;
      logic        cy, rn;
      logic [1:0]  state;
   } vec_t;

   vec_t tbl [29];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic p, input logic c, input logic l, input logic [15:0] lv);
      START = s; STOP = p; CLEAR = c; LOAD = l; LOAD_VAL = lv;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input string nm, input logic [15:0] b, input logic cy,
                            input logic rn, input logic [1:0] s);
      check({nm, ".bcd"}, 32'(BCD), 32'(b));
      check({nm, ".carry"}, 32'(CARRY), 32'(cy));
      check({nm, ".running"}, 32'(RUNNING), 32'(rn));
      check({nm, ".state"}, 32'(STATE), 32'(s));
   endtask

   initial begin
      int cnt;
      logic [15:0] exp_b;

      //             st    sp    cl    ld    load_val  bcd       cy    rn    state
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 2'b01};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h9998, 16'h9998, 1'b0, 1'b0, 2'b00};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1, 2'b01};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1, 2'b01};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1, 2'b01};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1, 2'b01};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1, 2'b01};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1, 2'b01};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 2'b01};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 2'b00};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA0F3, 16'h9093, 1'b0, 1'b0, 2'b00};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9093, 1'b0, 1'b0, 2'b00};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0004, 1'b0, 1'b0, 2'b00};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 2'b01};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 2'b01};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 2'b01};
      tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 2'b10};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 2'b10};
      tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 2'b01};
      tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b1, 2'b01};
      tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 2'b10};
      tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b1, 2'b01};
      tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b1, 2'b01};
      tbl[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b1, 2'b01};
      tbl[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b1, 2'b01};

      // Reset state, asserted asynchronously before any clock edge
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef CNT_CHAIN_CMP_EN
      CMP_VAL = 16'hFFFF;
`endif
      RES = 1'b1;
      #1 RES = 1'b0;
      #1 check_all("reset", 16'h0000, 1'b0, 1'b0, 2'b00);
      step();
      check_all("reset_held", 16'h0000, 1'b0, 1'b0, 2'b00);
      RES = 1'b1;

      for (int i = 0; i < 29; i++) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].ld, tbl[i].lv);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].cy, tbl[i].rn, tbl[i].state);
`ifdef CNT_CHAIN_CMP_EN
         check($sformatf("vec%0d.match", i), 32'(MATCH), 32'd0);
`endif
      end

      // Long run: one increment every PRESCALE edges, 0010 after 30 edges
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      check("run30.state0", 32'(STATE), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int n = 1; n <= 30; n++) begin
         step();
         cnt   = n / PRESCALE;
         exp_b = 16'((cnt / 10) * 16 + (cnt % 10));
         check($sformatf("run30.n%0d", n), 32'(BCD), 32'(exp_b));
      end

      // Asynchronous reset in the middle of a RUN cycle at 0042
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      check_all("pre_ares", 16'h0042, 1'b0, 1'b1, 2'b01);
      #2 RES = 1'b0;
      #1 check_all("ares_now", 16'h0000, 1'b0, 1'b0, 2'b00);
      step();
      RES = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step();
         check_all($sformatf("post_ares%0d", n), 16'h0000, 1'b0, 1'b0, 2'b00);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      check_all("post_ares_start", 16'h0000, 1'b0, 1'b1, 2'b01);

`ifdef CNT_CHAIN_CMP_EN
      // Compare stop at 0004, hold in DONE, resume to 0005
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      CMP_VAL = 16'h0004;
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int n = 1; n <= 12; n++) begin
         step();
         check($sformatf("cmp.bcd%0d", n), 32'(BCD), 32'(n / PRESCALE));
         check($sformatf("cmp.match%0d", n), 32'(MATCH), 32'(n == 12));
         check($sformatf("cmp.state%0d", n), 32'(STATE), (n == 12) ? 32'd3 : 32'd1);
      end
      for (int n = 0; n < 3; n++) begin
         step();
         check_all($sformatf("done_hold%0d", n), 16'h0004, 1'b0, 1'b0, 2'b11);
         check($sformatf("done_hold%0d.match", n), 32'(MATCH), 32'd0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      check_all("resume0", 16'h0004, 1'b0, 1'b1, 2'b01);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int n = 1; n <= 3; n++) begin
         step();
         check($sformatf("resume%0d", n), 32'(BCD), (n == 3) ? 32'h5 : 32'h4);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
